// File: rtl/student_or_pkg.sv
// Shared types and sizing helpers for the pipelined OR reduction tree.
package student_or_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   // Smallest r with 2^r >= v (v >= 2 in practice).
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Tree input width after zero-padding to a power of two.
   function automatic int unsigned pad_width(input int unsigned w);
      return 32'd1 << clog2(w);
   endfunction

   localparam int unsigned DEFAULT_PAD_W = pad_width(DEFAULT_WIDTH);

   // Per-beat sideband carried alongside the data through every tree level.
   typedef struct packed {
      logic valid;
      logic last;
      logic acc;
   } sb_t;

endpackage

// File: rtl/nand_gate.sv
// Two-input NAND primitive.
module nand_gate (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);

   assign y_o = ~(a_i & b_i);

endmodule

// File: rtl/student_or.sv
// Two-input OR cell built from NAND primitives: a|b = nand(nand(a,a), nand(b,b)).
module student_or (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);

   logic na;
   logic nb;

   nand_gate u_inv_a (.a_i(a_i), .b_i(a_i), .y_o(na));
   nand_gate u_inv_b (.a_i(b_i), .b_i(b_i), .y_o(nb));
   nand_gate u_out   (.a_i(na),  .b_i(nb),  .y_o(y_o));

endmodule

// File: rtl/student_or_level.sv
// One registered tree level: N inputs ORed pairwise into N/2 outputs,
// sideband registered alongside, everything held while en_i is low.
module student_or_level
   import student_or_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           en_i,
   input  logic [N-1:0]   data_i,
   input  sb_t            sb_i,
   output logic [N/2-1:0] data_o,
   output sb_t            sb_o
);

   logic [N/2-1:0] pair_or;
   logic [N/2-1:0] data_q, data_d;
   sb_t            sb_q, sb_d;

   for (genvar i = 0; i < N / 2; i++) begin : g_pair
      student_or u_or (
         .a_i (data_i[2*i]),
         .b_i (data_i[2*i+1]),
         .y_o (pair_or[i])
      );
   end

   // Capture the pairwise ORs and sideband only when the pipeline advances.
   always_comb begin
      data_d = data_q;
      sb_d   = sb_q;
      if (en_i) begin
         data_d = pair_or;
         sb_d   = sb_i;
      end
   end

   // Level register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         data_q <= '0;
         sb_q   <= '0;
      end else begin
         data_q <= data_d;
         sb_q   <= sb_d;
      end
   end

   assign data_o = data_q;
   assign sb_o   = sb_q;

endmodule

// File: rtl/student_or_tree_acc.sv
// Pipelined WIDTH-way OR reducer with valid/ready streaming and optional
// multi-beat packet accumulation. Optional out_first port enabled by
// defining STUDENT_OR_FIRST_IDX_EN.
module student_or_tree_acc
   import student_or_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   input  logic             in_acc,
   output logic             in_ready,
   output logic             out_hit,
   output logic [CNT_W-1:0] out_beats,
   output logic             out_valid,
`ifdef STUDENT_OR_FIRST_IDX_EN
   output logic [CNT_W-1:0] out_first,
`endif
   input  logic             out_ready
);

   localparam int unsigned LEVELS = clog2(WIDTH);
   localparam int unsigned PAD_W  = pad_width(WIDTH);
   localparam int unsigned NODES  = 2 * PAD_W - 1;

   // All tree levels packed into one vector: level k occupies
   // [2*PAD_W - 2*(PAD_W>>k) +: PAD_W>>k]; the final bit is the beat OR.
   logic [NODES-1:0]   node;
   sb_t  [LEVELS:0]    sb;
   logic               adv;
   logic               beat_or;
   sb_t                beat_sb;

   logic               out_valid_q, out_valid_d;
   logic               out_hit_q,   out_hit_d;
   logic [CNT_W-1:0]   out_beats_q, out_beats_d;
   logic               acc_hit_q,   acc_hit_d;
   logic [CNT_W-1:0]   acc_cnt_q,   acc_cnt_d;
   logic               acc_open_q,  acc_open_d;
   logic [CNT_W-1:0]   cnt_base;
   logic [CNT_W-1:0]   cnt_inc;
   logic               hit_base;
`ifdef STUDENT_OR_FIRST_IDX_EN
   logic [CNT_W-1:0]   out_first_q, out_first_d;
   logic [CNT_W-1:0]   acc_first_q, acc_first_d;
   logic [CNT_W-1:0]   first_next;
`endif

   assign adv      = !out_valid_q | out_ready;
   assign in_ready = adv;

   assign node[WIDTH-1:0] = in_data;
   if (PAD_W > WIDTH) begin : g_pad
      assign node[PAD_W-1:WIDTH] = '0;
   end

   assign sb[0] = '{valid: in_valid, last: in_last, acc: in_acc};

   for (genvar k = 0; k < LEVELS; k++) begin : g_level
      localparam int unsigned NI    = PAD_W >> k;
      localparam int unsigned OFF_I = 2 * PAD_W - 2 * NI;
      localparam int unsigned OFF_O = OFF_I + NI;
      student_or_level #(.N(NI)) u_level (
         .clk_i  (clk),
         .rst_ni (rst_n),
         .en_i   (adv),
         .data_i (node[OFF_I +: NI]),
         .sb_i   (sb[k]),
         .data_o (node[OFF_O +: NI/2]),
         .sb_o   (sb[k+1])
      );
   end

   assign beat_or = node[NODES-1];
   assign beat_sb = sb[LEVELS];

   // Running packet state only counts while a packet is open.
   assign cnt_base = acc_open_q ? acc_cnt_q : '0;
   assign hit_base = acc_open_q & acc_hit_q;
   assign cnt_inc  = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
`ifdef STUDENT_OR_FIRST_IDX_EN
   assign first_next = hit_base ? acc_first_q : (beat_or ? cnt_base : '0);
`endif

   // Accumulator next state: close on per-beat mode or last beat, else extend packet.
   always_comb begin
      out_valid_d = out_valid_q;
      out_hit_d   = out_hit_q;
      out_beats_d = out_beats_q;
      acc_hit_d   = acc_hit_q;
      acc_cnt_d   = acc_cnt_q;
      acc_open_d  = acc_open_q;
`ifdef STUDENT_OR_FIRST_IDX_EN
      out_first_d = out_first_q;
      acc_first_d = acc_first_q;
`endif
      if (adv) begin
         if (beat_sb.valid) begin
            if (!beat_sb.acc | beat_sb.last) begin
               out_valid_d = 1'b1;
               out_hit_d   = hit_base | beat_or;
               out_beats_d = cnt_inc;
               acc_hit_d   = 1'b0;
               acc_cnt_d   = '0;
               acc_open_d  = 1'b0;
`ifdef STUDENT_OR_FIRST_IDX_EN
               out_first_d = first_next;
               acc_first_d = '0;
`endif
            end else begin
               acc_hit_d   = hit_base | beat_or;
               acc_cnt_d   = cnt_inc;
               acc_open_d  = 1'b1;
`ifdef STUDENT_OR_FIRST_IDX_EN
               acc_first_d = first_next;
`endif
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // Accumulator and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_hit_q   <= 1'b0;
         out_beats_q <= '0;
         acc_hit_q   <= 1'b0;
         acc_cnt_q   <= '0;
         acc_open_q  <= 1'b0;
`ifdef STUDENT_OR_FIRST_IDX_EN
         out_first_q <= '0;
         acc_first_q <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_hit_q   <= out_hit_d;
         out_beats_q <= out_beats_d;
         acc_hit_q   <= acc_hit_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_open_q  <= acc_open_d;
`ifdef STUDENT_OR_FIRST_IDX_EN
         out_first_q <= out_first_d;
         acc_first_q <= acc_first_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_hit   = out_hit_q;
   assign out_beats = out_beats_q;
`ifdef STUDENT_OR_FIRST_IDX_EN
   assign out_first = out_first_q;
`endif

endmodule
